peak_report_tx: RTL and testbench
=================================

# peak_report_tx

Window-timing and readout companion to the 32-bit absolute-peak detector in the DDC monitor path. It generates the periodic window pulse that closes each detector measurement window. After a fixed settling delay it captures the detector's latched peak and tags it with a 16-bit window sequence number. The tagged word is queued in a small FIFO and delivered to the host/packetiser over a valid/ready stream, with dropped reports counted.

## Interface
- PERIOD, 150000, clk cycles per measurement window (1 ms at 150 MHz); legal range 8..2^24.
- CAP_DLY, 3, cycles from window pulse to peak capture; must be ≥2 (detector updates its output 2 cycles after the pulse); legal range 2..15.
- DEPTH, 4, report FIFO depth; power of two, 2..16.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable; low holds the window counter and suppresses pulses.
- ms_out  out  1  window pulse to detector ms_in; one cycle high per window.
- peak_in  in  32  detector max output (unsigned magnitude, bit 31 always 0).
- tx_data  out  48  {seq[15:0], peak[31:0]}; valid only while tx_valid is high.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accept.
- overflow_cnt  out  16  saturating count of reports dropped on FIFO full.

## Operation
- Window counter cnt, 24 bit. While en=1: cnt increments each cycle and wraps PERIOD-1→0. While en=0: cnt is forced to 0.
- ms_out is registered; it is 1 in the cycle after one in which en=1 and cnt=PERIOD-1. With en held high, pulses are exactly PERIOD cycles apart. The first pulse follows PERIOD cycles after en is first sampled high.
- en falling mid-window: no pulse, counter clears. A pulse already issued still completes its capture.
- Capture: a CAP_DLY-stage shift register is loaded with ms_out. Its tail asserts cap for one cycle, CAP_DLY cycles after the ms_out cycle. cap samples peak_in and the current seq.
- seq, 16 bit: starts at 0 and increments by 1, mod 2^16, on every cap, including dropped captures, so gaps are visible downstream. The seq=0 report covers the partial window after enable; the host discards it.
- FIFO: DEPTH×48, registered read data, first-word-fall-through.
  - push=cap, pop=tx_valid&tx_ready.
  - A push is accepted if count<DEPTH, or if count=DEPTH and a pop occurs in the same cycle.
  - If count=DEPTH with no pop, the new report is dropped and overflow_cnt increments, saturating at 0xFFFF.
  - Simultaneous push and pop on an empty FIFO is impossible, because valid is 0.
- tx_data and tx_valid must stay stable while tx_valid=1 and tx_ready=0.
- rst clears cnt, the shift register, seq, FIFO pointers/count and overflow_cnt, aborting any in-flight capture.

## Timing
- Reset values: ms_out=0, tx_valid=0, tx_data=0, overflow_cnt=0.
- Pulse→capture latency is CAP_DLY cycles. Capture→tx_valid is 1 cycle when the FIFO is empty.
- Throughput: one report per cycle out; at most one in per PERIOD.
- rst takes priority over en, cap and pop in the same cycle.

## Test plan
- PERIOD=8, CAP_DLY=3, en high from cycle 0 after reset, tx_ready=1, peak_in ramped as 100+cycle:
  - ms_out pulses at cycles 8, 16, 24.
  - Reports are {0,111}, {1,119}, {2,127}; each tx_valid rises 1 cycle after its capture and is held for a single cycle.
- tx_ready=0, DEPTH=4, 6 windows:
  - 4 reports are queued with seq 0..3 and overflow_cnt=2.
  - After tx_ready=1, the outputs are seq 0,1,2,3 in order and the next report carries seq 6.
- FIFO full with a cap coinciding with a single-cycle tx_ready pulse: seq 0 is popped, the new report is accepted, count stays 4, and overflow_cnt is unchanged.
- en dropped at cnt=5 and raised 10 cycles later:
  - No pulse occurs during the low period.
  - The next pulse comes exactly PERIOD cycles after the re-enable.
  - A capture pending at the drop still enqueues.
- rst asserted 1 cycle after ms_out: no capture, FIFO empty, seq restarts at 0, all outputs are 0 in the cycle after rst.
- Backpressure hold: tx_ready toggled pseudo-randomly; tx_data is stable while tx_valid&!tx_ready, and every seq is delivered exactly once, in order.

Source files
------------

// File: rtl/peak_report_tx_if.sv
// rtl/peak_report_tx_if.sv - report stream between peak_report_tx and the host packetiser
interface peak_report_tx_if;
    logic [47:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/peak_report_tx.sv
// rtl/peak_report_tx.sv - window pulse generator, delayed peak capture and tagged report FIFO
module peak_report_tx #(
    parameter int PERIOD  = 150000,
    parameter int CAP_DLY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    ms_out,
    input  logic [31:0]             peak_in,
    peak_report_tx_if.master        tx,
    output logic [15:0]             overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [23:0] LAST = 24'(PERIOD - 1);

    logic [23:0]        r_cnt;
    logic               r_ms;
    logic [CAP_DLY-1:0] r_sr;
    logic [15:0]        r_seq;
    logic [47:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wr;
    logic [AW-1:0]      r_rd;
    logic [CW-1:0]      r_count;
    logic [15:0]        r_ovf;

    logic w_cap;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    assign w_cap  = r_sr[CAP_DLY-1];
    assign w_pop  = tx.tx_valid & tx.tx_ready;
    assign w_full = (r_count == CW'(DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

    assign ms_out       = r_ms;
    assign tx.tx_valid  = (r_count != '0);
    assign tx.tx_data   = r_mem[r_rd];
    assign overflow_cnt = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ms  <= 1'b0;
        end else begin
            r_ms  <= en && (r_cnt == LAST);
            if (!en || r_cnt == LAST)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 24'd1;
        end
    end

    // Delay line gives the detector time to latch the closed window's peak.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_seq <= '0;
        end else begin
            r_sr <= {r_sr[CAP_DLY-2:0], r_ms};
            if (w_cap)
                r_seq <= r_seq + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr <= '0;
        end else if (w_push) begin
            r_mem[r_wr] <= {r_seq, peak_in};
            r_wr        <= r_wr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= '0;
        end else begin
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && r_ovf != 16'hFFFF)
                r_ovf <= r_ovf + 16'd1;
        end
    end
endmodule

// File: tb/tb_peak_report_tx.sv
// tb/tb_peak_report_tx.sv - scoreboard bench for peak_report_tx
module tb_peak_report_tx;
    localparam int PERIOD  = 8;
    localparam int CAP_DLY = 3;
    localparam int DEPTH   = 4;

    typedef logic [63:0] w64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] peak_in = '0;
    wire         ms_out;
    wire  [15:0] overflow_cnt;

    peak_report_tx_if u_if ();

    peak_report_tx #(.PERIOD(PERIOD), .CAP_DLY(CAP_DLY), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ms_out       (ms_out),
        .peak_in      (peak_in),
        .tx           (u_if),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    w64 ms_log[$];
    w64 v_log[$];
    w64 d_log[$];

    task automatic expect_eq(input string tag, input w64 got, input w64 exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cmp_list(input string tag, input w64 got[$], input w64 exp[$]);
        expect_eq({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size())
                expect_eq(tag, got[i], exp[i]);
    endtask

    function automatic w64 rep(input int s, input int p);
        return {16'h0, 16'(s), 32'(p)};
    endfunction

    // Reference model: advanced at each clock edge from the inputs live before it.
    int          m_cnt = 0;
    int          m_cd  = -1;
    bit          m_ms  = 1'b0;
    logic [15:0] m_seq = '0;
    logic [15:0] m_ovf = '0;
    logic [47:0] m_fifo[$];
    bit          cap_now, pop_now, acc;
    logic [47:0] m_rep;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_cd = -1; m_ms = 1'b0; m_seq = '0; m_ovf = '0;
            m_fifo.delete();
        end else begin
            cap_now = (m_cd == 0);
            if (m_cd >= 0) m_cd--;
            if (m_ms) m_cd = CAP_DLY - 1;
            pop_now = (m_fifo.size() != 0) && u_if.tx_ready;
            acc     = cap_now && (m_fifo.size() < DEPTH || pop_now);
            m_rep   = {m_seq, peak_in};
            if (cap_now) m_seq = m_seq + 16'd1;
            if (pop_now) void'(m_fifo.pop_front());
            if (acc) m_fifo.push_back(m_rep);
            else if (cap_now && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            m_ms  = en && (m_cnt == PERIOD - 1);
            m_cnt = (!en || m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
        end
    end

    bit          h_pend = 1'b0;
    logic [47:0] h_data = '0;

    always @(negedge clk) begin
        if (started) begin
            expect_eq("ms_out", 64'(ms_out), 64'(m_ms));
            expect_eq("tx_valid", 64'(u_if.tx_valid), 64'(m_fifo.size() != 0));
            expect_eq("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
            if (m_fifo.size() != 0)
                expect_eq("tx_data", 64'(u_if.tx_data), 64'(m_fifo[0]));
            if (h_pend) begin
                expect_eq("hold_valid", 64'(u_if.tx_valid), 64'd1);
                expect_eq("hold_data", 64'(u_if.tx_data), 64'(h_data));
            end
            if (ms_out) ms_log.push_back(64'(cyc));
            if (u_if.tx_valid) v_log.push_back(64'(cyc));
            if (u_if.tx_valid && u_if.tx_ready) d_log.push_back(64'(u_if.tx_data));
        end
        h_pend = u_if.tx_valid && !u_if.tx_ready && !rst;
        h_data = u_if.tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        peak_in = 32'(100 + cyc);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Cycle 0 is the first cycle with rst low and en high.
    task automatic start_run(input bit rdy);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        started = 1'b1;
        ms_log.delete(); v_log.delete(); d_log.delete();
        rst = 1'b0;
        en  = 1'b1;
        u_if.tx_ready = rdy;
        cyc = 0;
        peak_in = 32'd100;
    endtask

    w64 e[$];
    w64 e2[$];

    initial begin
        u_if.tx_ready = 1'b0;

        start_run(1'b1);
        expect_eq("rst_ms_out", 64'(ms_out), 64'd0);
        expect_eq("rst_tx_valid", 64'(u_if.tx_valid), 64'd0);
        expect_eq("rst_tx_data", 64'(u_if.tx_data), 64'd0);
        expect_eq("rst_overflow", 64'(overflow_cnt), 64'd0);
        run_to(30);
        e = '{64'd8, 64'd16, 64'd24};
        cmp_list("t1_pulse", ms_log, e);
        e = '{rep(0, 111), rep(1, 119), rep(2, 127)};
        cmp_list("t1_report", d_log, e);
        e = '{64'd12, 64'd20, 64'd28};
        cmp_list("t1_valid_cyc", v_log, e);

        start_run(1'b0);
        run_to(52);
        expect_eq("t2_valid", 64'(u_if.tx_valid), 64'd1);
        expect_eq("t2_head_seq", 64'(u_if.tx_data[47:32]), 64'd0);
        expect_eq("t2_overflow", 64'(overflow_cnt), 64'd2);
        u_if.tx_ready = 1'b1;
        run_to(62);
        e = '{rep(0, 111), rep(1, 119), rep(2, 127), rep(3, 135), rep(6, 159)};
        cmp_list("t2_drain", d_log, e);

        start_run(1'b0);
        run_to(51);
        u_if.tx_ready = 1'b1;
        run_to(52);
        u_if.tx_ready = 1'b0;
        expect_eq("t3_overflow", 64'(overflow_cnt), 64'd1);
        expect_eq("t3_head_seq", 64'(u_if.tx_data[47:32]), 64'd1);
        run_to(53);
        u_if.tx_ready = 1'b1;
        run_to(57);
        expect_eq("t3_empty", 64'(u_if.tx_valid), 64'd0);
        e = '{rep(0, 111), rep(1, 119), rep(2, 127), rep(3, 135), rep(5, 151)};
        cmp_list("t3_order", d_log, e);

        start_run(1'b1);
        run_to(13);
        en = 1'b0;
        run_to(23);
        en = 1'b1;
        run_to(32);
        en = 1'b0;
        run_to(40);
        en = 1'b1;
        run_to(45);
        e = '{64'd8, 64'd31};
        cmp_list("t4_pulse", ms_log, e);
        e = '{rep(0, 111), rep(1, 134)};
        cmp_list("t4_report", d_log, e);

        start_run(1'b0);
        run_to(17);
        rst = 1'b1;
        run_to(18);
        rst = 1'b0;
        u_if.tx_ready = 1'b1;
        expect_eq("t5_ms_out", 64'(ms_out), 64'd0);
        expect_eq("t5_tx_valid", 64'(u_if.tx_valid), 64'd0);
        expect_eq("t5_tx_data", 64'(u_if.tx_data), 64'd0);
        expect_eq("t5_overflow", 64'(overflow_cnt), 64'd0);
        ms_log.delete(); v_log.delete(); d_log.delete();
        run_to(32);
        e = '{64'd26};
        cmp_list("t5_pulse", ms_log, e);
        e = '{rep(0, 129)};
        cmp_list("t5_report", d_log, e);

        start_run(1'b0);
        for (int i = 0; i < 400; i++) begin
            u_if.tx_ready = ($urandom_range(0, 9) < 2);
            tick();
        end
        en = 1'b0;
        u_if.tx_ready = 1'b1;
        run_to(425);
        expect_eq("bp_drained", 64'(u_if.tx_valid), 64'd0);
        expect_eq("bp_total", 64'(d_log.size()) + 64'(overflow_cnt), 64'(400 / PERIOD));
        if (d_log.size() != 0)
            expect_eq("bp_first_seq", 64'(d_log[0][47:32]), 64'd0);
        for (int i = 1; i < d_log.size(); i++)
            expect_eq("bp_order", 64'(d_log[i][47:32] > d_log[i-1][47:32]), 64'd1);
        e2 = d_log;
        expect_eq("bp_delivered_some", 64'(e2.size() > 10), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
